// File: rtl/byte_basher_pkg.sv
// byte_basher_pkg: shared constants and FSM encoding for the sensor front end
package byte_basher_pkg;
    localparam int DEFAULT_NUM_SENSORS = 3;
    localparam int HIT_COUNT_W = 8;
    localparam logic [1:0] ARMED = 2'd0;
    localparam logic [1:0] LOCKOUT = 2'd1;
    localparam logic [1:0] WAIT_RELEASE = 2'd2;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: two-flop synchroniser plus stable-count debounce for one raw line
module sensor_debounce
    import byte_basher_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            cnt <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/hit_sensor_frontend.sv
// hit_sensor_frontend: debounced sensor lines feeding a rising-edge arbiter with post-hit lockout
module hit_sensor_frontend
    import byte_basher_pkg::*;
#(
    parameter int NUM_SENSORS = DEFAULT_NUM_SENSORS,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LOCKOUT_CYCLES = 5000000
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] GPIO_1,
    output logic [NUM_SENSORS-1:0] sensor_input,
    output logic                   hit_detected,
    output logic [NUM_SENSORS-1:0] sensor_level,
    output logic                   busy,
    output logic [HIT_COUNT_W-1:0] hit_count
);
    localparam int LW = cnt_w(LOCKOUT_CYCLES);
    logic [1:0] state;
    logic [LW-1:0] lock_cnt;
    logic [NUM_SENSORS-1:0] level_d;
    logic [NUM_SENSORS-1:0] rise;
    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_line
        sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(CLOCK_50),
            .rst(reset),
            .raw(GPIO_1[i]),
            .level(sensor_level[i])
        );
    end
    assign rise = sensor_level & ~level_d;
    // Leaving lockout with every line already released skips WAIT_RELEASE, giving LOCKOUT_CYCLES+1 hit spacing
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= ARMED;
            lock_cnt <= '0;
            level_d <= '0;
            sensor_input <= '0;
            hit_detected <= 1'b0;
            busy <= 1'b0;
            hit_count <= '0;
        end else begin
            level_d <= sensor_level;
            hit_detected <= 1'b0;
            busy <= state != ARMED;
            if (!enable) begin
                state <= ARMED;
            end else begin
                case (state)
                    ARMED: if (|rise) begin
                        hit_detected <= 1'b1;
                        sensor_input <= rise & (~rise + NUM_SENSORS'(1));
                        hit_count <= hit_count + HIT_COUNT_W'(hit_count != '1);
                        lock_cnt <= LW'(LOCKOUT_CYCLES - 1);
                        state <= LOCKOUT;
                    end
                    LOCKOUT: if (lock_cnt == '0) state <= (|sensor_level) ? WAIT_RELEASE : ARMED;
                             else lock_cnt <= lock_cnt - 1'b1;
                    WAIT_RELEASE: if (!(|sensor_level)) state <= ARMED;
                    default: state <= ARMED;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hit_sensor_frontend.sv
// tb_hit_sensor_frontend: directed and random stimulus checked each cycle against a timestamp-based model
module tb_hit_sensor_frontend;
    localparam int N = 3;
    localparam int D = 4;
    localparam int L = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic [N-1:0] raw = '0;
    logic [N-1:0] sensor_input, sensor_level;
    logic hit_detected, busy;
    logic [7:0] hit_count;
    int asserts = 0;
    int fails = 0;
    int pulses = 0;
    logic [N-1:0] m_s1, m_s2, m_lvl, m_lvl_d, m_si;
    int m_run [N];
    longint cyc = 0;
    longint lock_end;
    bit need_rel, m_hit, m_busy;
    int m_cnt;

    always #5 clk = ~clk;

    hit_sensor_frontend #(.NUM_SENSORS(N), .DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .enable(en),
        .GPIO_1(raw),
        .sensor_input(sensor_input),
        .hit_detected(hit_detected),
        .sensor_level(sensor_level),
        .busy(busy),
        .hit_count(hit_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        asserts++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_d = '0; m_si = '0;
        foreach (m_run[i]) m_run[i] = 0;
        lock_end = 0; need_rel = 0; m_hit = 0; m_busy = 0; m_cnt = 0;
    endtask

    // Armed means the lockout window has expired and a release has been seen since the last hit
    task automatic model_edge();
        logic [N-1:0] rise, nl;
        bit armed;
        if (rst) begin
            model_reset();
        end else begin
            rise = m_lvl & ~m_lvl_d;
            armed = (cyc >= lock_end) && !need_rel;
            m_busy = !armed;
            m_hit = 0;
            if (!en) begin
                lock_end = 0;
                need_rel = 0;
            end else if (armed && rise != '0) begin
                m_hit = 1;
                for (int i = N - 1; i >= 0; i--) if (rise[i]) m_si = N'(1) << i;
                m_cnt++;
                lock_end = cyc + 1 + L;
                need_rel = 1;
            end else if (cyc >= lock_end - 1 && m_lvl == '0) begin
                need_rel = 0;
            end
            nl = m_lvl;
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        nl[i] = ~nl[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_lvl_d = m_lvl;
            m_lvl = nl;
            m_s2 = m_s1;
            m_s1 = raw;
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (hit_detected === 1'b1) pulses++;
        chk("hit_detected", 32'(hit_detected), 32'(m_hit));
        chk("sensor_input", 32'(sensor_input), 32'(m_si));
        chk("sensor_level", 32'(sensor_level), 32'(m_lvl));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("hit_count", 32'(hit_count), 32'(m_cnt > 255 ? 255 : m_cnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int p;
        model_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        en = 1'b0; raw = 3'b010;
        idle(10);
        chk("gate_pulses", 32'(pulses), 0);
        chk("gate_count", 32'(hit_count), 0);
        en = 1'b1;
        idle(12);
        chk("gate_raise_pulses", 32'(pulses), 0);
        chk("gate_raise_count", 32'(hit_count), 0);
        raw = '0;
        idle(10);
        raw = 3'b010;
        idle(6);
        chk("press_early", 32'(hit_detected), 0);
        step();
        chk("press_hit", 32'(hit_detected), 1);
        chk("press_code", 32'(sensor_input), 32'(3'b010));
        chk("press_count", 32'(hit_count), 1);
        for (int c = 8; c <= 15; c++) begin
            step();
            chk("press_busy", 32'(busy), 1);
        end
        step();
        chk("held_busy", 32'(busy), 1);
        raw = '0;
        idle(12);
        chk("release_busy", 32'(busy), 0);
        for (int i = 0; i < 20; i++) begin
            raw = ((i / 2) % 2 == 0) ? 3'b001 : 3'b000;
            step();
            chk("bounce_level", 32'(sensor_level[0]), 0);
        end
        p = pulses;
        raw = 3'b001;
        idle(6);
        chk("bounce_early", 32'(pulses - p), 0);
        step();
        chk("bounce_hit", 32'(hit_detected), 1);
        idle(20);
        chk("bounce_once", 32'(pulses - p), 1);
        raw = '0;
        idle(16);
        p = pulses;
        raw = 3'b110;
        idle(7);
        chk("simul_hit", 32'(hit_detected), 1);
        chk("simul_code", 32'(sensor_input), 32'(3'b010));
        idle(30);
        chk("simul_once", 32'(pulses - p), 1);
        raw = '0;
        idle(16);
        p = pulses;
        raw = 3'b001;
        idle(7);
        chk("hold_hit", 32'(hit_detected), 1);
        step();
        raw = 3'b101;
        idle(32);
        chk("hold_once", 32'(pulses - p), 1);
        raw = '0;
        idle(16);
        chk("hold_busy_clear", 32'(busy), 0);
        raw = 3'b100;
        idle(7);
        chk("line2_hit", 32'(hit_detected), 1);
        chk("line2_code", 32'(sensor_input), 32'(3'b100));
        raw = '0;
        idle(20);
        raw = 3'b010;
        idle(7);
        chk("lock_hit", 32'(hit_detected), 1);
        idle(3);
        chk("lock_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_async_hit", 32'(hit_detected), 0);
        chk("rst_async_code", 32'(sensor_input), 0);
        chk("rst_async_level", 32'(sensor_level), 0);
        chk("rst_async_busy", 32'(busy), 0);
        chk("rst_async_count", 32'(hit_count), 0);
        model_reset();
        idle(2);
        rst = 1'b0;
        idle(6);
        chk("post_rst_early", 32'(hit_detected), 0);
        step();
        chk("post_rst_hit", 32'(hit_detected), 1);
        chk("post_rst_count", 32'(hit_count), 1);
        raw = '0;
        idle(20);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) raw = N'($urandom);
            if ($urandom_range(0, 99) == 0) en = ~en;
            step();
        end
        en = 1'b1; raw = '0;
        idle(20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        p = pulses;
        for (int h = 0; h < 300; h++) begin
            raw = N'(1) << $urandom_range(0, N - 1);
            idle($urandom_range(8, 12));
            raw = '0;
            idle(16);
        end
        chk("sat_pulses", 32'(pulses - p), 300);
        chk("sat_count", 32'(hit_count), 255);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
